rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port among NREQ writeback sources
//  (main pipeline, multi-cycle mul/div, load return). Round-robin arbitration
//  with valid/ready handshakes, a registered write stage driving RF
//  RFWr/A3/WD/pc, and a 32-entry busy scoreboard that decode uses for RAW
//  stalls. Sits between the writeback sources and the register file.
// PARAMETERS
//  NREQ   3  number of writeback requesters (2..8)
//  PRIO0  1  1: requester 0 (main pipeline) has strict priority over round-robin
// PORTS
//  clk        in   1        clock
//  rst        in   1        reset, asynchronous, active-high
//  req_valid  in   NREQ     requester i has a write pending
//  req_ready  out  NREQ     one-hot grant; transfer when valid&ready
//  req_addr   in   NREQ*5   dest reg of req i, bits [5i+4:5i]
//  req_data   in   NREQ*32  write data of req i, bits [32i+31:32i]
//  req_pc     in   NREQ*32  pc of producing instruction (trace only)
//  set_en     in   1        decode issued an instruction writing set_addr
//  set_addr   in   5        dest reg to mark busy
//  flush      in   1        sync pipeline flush: clear scoreboard
//  rf_we      out  1        RF write enable (to RFWr)
//  rf_waddr   out  5        RF write address (to A3)
//  rf_wdata   out  32       RF write data (to WD)
//  rf_pc      out  32       pc of written instruction
//  busy       out  32       busy[r]=1: write to r outstanding; busy[0] always 0
// BEHAVIOUR
//  Reset: rf_we=0, rf_waddr=0, rf_wdata=0, rf_pc=0, busy=0, rr_ptr=0;
//   req_ready=0 while rst high.
//  Arbitration (combinational, every cycle, no idle cycles):
//   - PRIO0=1 and req_valid[0]: grant 0, rr_ptr unchanged.
//   - else grant first i with req_valid[i], searching rr_ptr, rr_ptr+1, ...
//     mod NREQ; at most one req_ready bit high; none if no valid.
//   - on transfer of i by round-robin: rr_ptr <= (i+1) mod NREQ.
//   - req_ready depends on req_valid, not on other inputs; requesters hold
//     valid/addr/data/pc stable until accepted; valid never retracted.
//   - flush=1: req_ready=0 that cycle (no new transfers).
//  Write stage: transfer in cycle N -> rf_we=1 with addr/data/pc of the
//   winner in cycle N+1, exactly one cycle; back-to-back transfers give
//   continuous rf_we. No transfer in N -> rf_we=0 in N+1; addr/data/pc hold.
//   Writes to r0 are accepted (ready asserted) but give rf_we=0.
//   An accepted write already in the write stage completes despite flush.
//  Scoreboard:
//   - set: set_en && set_addr!=0 -> busy[set_addr]<=1 at next edge.
//   - clear: rf_we=1 in cycle N+1 -> busy[rf_waddr]<=0 at edge ending N+1
//     (RF has written it on that cycle's negedge).
//   - set and clear of same reg same edge: set wins (younger producer).
//   - flush: busy<=0 at next edge, overriding set and clear.
//   - busy bit already 1 and set again: stays 1 (no counting; one
//     outstanding producer per reg is decode's responsibility).
//  Reset asserted mid-transfer: pending write is dropped; rf_we=0 at once.
// TESTING
//  1 rst pulse mid-run -> rf_we, busy, req_ready 0 immediately; rr_ptr=0.
//  2 req_valid=3'b001, addr=5, data=32'hDEADBEEF, pc=32'h1C000010 ->
//    ready[0] same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=DEADBEEF.
//  3 PRIO0=0, req_valid=3'b111 held, each re-raised after accept -> grants
//    0,1,2,0,1,2; rf_we high every cycle after the first.
//  4 PRIO0=1, req 0 and 2 valid 4 cycles -> grant 0 every cycle, 2 starves
//    until req 0 drops, then granted next cycle.
//  5 set_en addr 7 -> busy[7]=1; write r7 accepted cycle N -> busy[7]=0
//    after N+1; set r7 in cycle N+1 as well -> busy[7] stays 1.
//  6 write to r0 -> accepted, rf_we=0; set_en addr 0 -> busy[0]=0; flush
//    with busy=32'h0000_00F0 -> busy=0, req_ready=0 that cycle.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin (optional strict priority for
// requester 0) over NREQ sources, one registered write stage, RAW busy scoreboard.
module rf_wb_arbiter #(
  parameter int NREQ  = 3,
  parameter bit PRIO0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_addr,
  input  logic [NREQ*32-1:0]   req_data,
  input  logic [NREQ*32-1:0]   req_pc,
  input  logic                 set_en,
  input  logic [4:0]           set_addr,
  input  logic                 flush,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [31:0]          rf_pc,
  output logic [31:0]          busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   rr_nxt;
  logic [NREQ-1:0] grant;
  logic            vld_p0;
  logic [4:0]      addr_p0;
  logic [31:0]     data_p0;
  logic [31:0]     pc_p0;
  logic [31:0]     busy_nxt;

  // Stage p0: grant selection and winner mux, all combinational from req_valid
  always_comb begin
    int  idx;
    logic found;
    grant   = '0;
    addr_p0 = '0;
    data_p0 = '0;
    pc_p0   = '0;
    rr_nxt  = rr_ptr;
    idx     = 0;
    found   = 1'b0;
    if (!rst && !flush) begin
      if (PRIO0 && req_valid[0]) begin
        grant[0] = 1'b1;
        addr_p0  = req_addr[4:0];
        data_p0  = req_data[31:0];
        pc_p0    = req_pc[31:0];
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          idx = int'(rr_ptr) + k;
          if (idx >= NREQ) idx = idx - NREQ;
          if (!found && req_valid[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            addr_p0     = req_addr[idx*5 +: 5];
            data_p0     = req_data[idx*32 +: 32];
            pc_p0       = req_pc[idx*32 +: 32];
            rr_nxt      = (idx == NREQ - 1) ? '0 : IW'(idx + 1);
          end
        end
      end
    end
  end

  assign req_ready = grant;
  assign vld_p0    = |grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr <= '0;
    else     rr_ptr <= rr_nxt;
  end

  // Stage p1: registered RF write port; r0 writes are consumed without a write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rf_pc    <= '0;
    end else begin
      rf_we <= vld_p0 && (addr_p0 != 5'd0);
      if (vld_p0) begin
        rf_waddr <= addr_p0;
        rf_wdata <= data_p0;
        rf_pc    <= pc_p0;
      end
    end
  end

  // Set after clear so a younger producer keeps the register busy; flush beats both
  always_comb begin
    busy_nxt = busy;
    if (rf_we) busy_nxt[rf_waddr] = 1'b0;
    if (set_en && (set_addr != 5'd0)) busy_nxt[set_addr] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a PRIO0=1 and a PRIO0=0 instance share
// stimulus; RF writes of the priority instance are checked against a queue.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [95:0] req_pc;
  logic        set_en;
  logic [4:0]  set_addr;
  logic        flush;

  logic [2:0]  req_ready,  req_ready_rr;
  logic        rf_we,      rf_we_rr;
  logic [4:0]  rf_waddr,   rf_waddr_rr;
  logic [31:0] rf_wdata,   rf_wdata_rr;
  logic [31:0] rf_pc,      rf_pc_rr;
  logic [31:0] busy,       busy_rr;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  rf_wb_arbiter #(.NREQ(3), .PRIO0(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_pc(req_pc),
    .set_en(set_en), .set_addr(set_addr), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_pc(rf_pc),
    .busy(busy)
  );

  rf_wb_arbiter #(.NREQ(3), .PRIO0(1'b0)) dut_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_rr),
    .req_addr(req_addr), .req_data(req_data), .req_pc(req_pc),
    .set_en(set_en), .set_addr(set_addr), .flush(flush),
    .rf_we(rf_we_rr), .rf_waddr(rf_waddr_rr), .rf_wdata(rf_wdata_rr), .rf_pc(rf_pc_rr),
    .busy(busy_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    req_addr[i*5 +: 5]  = a;
    req_data[i*32 +: 32] = d;
    req_pc[i*32 +: 32]   = p;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    wr_t w;
    w.a = a; w.d = d; w.p = p;
    exp_q.push_back(w);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every RF write of the priority instance must match the next expected entry
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      check("write_expected", 32'(exp_q.size() > 0), 32'h1);
      if (exp_q.size() > 0) begin
        wr_t w;
        w = exp_q.pop_front();
        check("sb_waddr", 32'(rf_waddr), 32'(w.a));
        check("sb_wdata", rf_wdata, w.d);
        check("sb_pc", rf_pc, w.p);
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; req_pc = '0;
    set_en = 1'b0; set_addr = '0; flush = 1'b0;
    step(); step();
    req_valid = 3'b001;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_rf_we", 32'(rf_we), 32'h0);
    check("rst_waddr", 32'(rf_waddr), 32'h0);
    check("rst_wdata", rf_wdata, 32'h0);
    check("rst_pc", rf_pc, 32'h0);
    check("rst_busy", busy, 32'h0);
    req_valid = 3'b000;
    rst = 1'b0;

    // Single write from requester 0
    step();
    set_req(0, 5'd5, 32'hDEADBEEF, 32'h1C000010);
    req_valid = 3'b001;
    push(5'd5, 32'hDEADBEEF, 32'h1C000010);
    #1;
    check("t2_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 3'b000;
    check("t2_we", 32'(rf_we), 32'h1);
    check("t2_waddr", 32'(rf_waddr), 32'd5);
    check("t2_wdata", rf_wdata, 32'hDEADBEEF);
    check("t2_pc", rf_pc, 32'h1C000010);
    step();
    check("t2_we_drop", 32'(rf_we), 32'h0);
    check("t2_waddr_hold", 32'(rf_waddr), 32'd5);

    // Reset pulse while a write sits in the write stage
    set_en = 1'b1; set_addr = 5'd3;
    set_req(0, 5'd9, 32'h11111111, 32'h00000100);
    req_valid = 3'b001;
    step();
    set_en = 1'b0; req_valid = 3'b000;
    check("t1_busy_pre", busy, 32'h00000008);
    rst = 1'b1;
    req_valid = 3'b001;
    #1;
    check("t1_rf_we", 32'(rf_we), 32'h0);
    check("t1_busy", busy, 32'h0);
    check("t1_ready", 32'(req_ready), 32'h0);
    check("t1_ready_rr", 32'(req_ready_rr), 32'h0);
    req_valid = 3'b000;
    step();
    rst = 1'b0;

    // Round-robin rotation on the PRIO0=0 instance; priority instance always picks 0
    step();
    set_req(0, 5'd1, 32'hA0A0A0A0, 32'h00001000);
    set_req(1, 5'd2, 32'hB1B1B1B1, 32'h00001004);
    set_req(2, 5'd3, 32'hC2C2C2C2, 32'h00001008);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      push(5'd1, 32'hA0A0A0A0, 32'h00001000);
      #1;
      check("t3_rr_grant", 32'(req_ready_rr), 32'(1 << (k % 3)));
      check("t3_prio_grant", 32'(req_ready), 32'h1);
      if (k > 0) begin
        check("t3_rr_we", 32'(rf_we_rr), 32'h1);
        check("t3_rr_waddr", 32'(rf_waddr_rr), 32'((k - 1) % 3 + 1));
      end
      step();
    end
    req_valid = 3'b000;
    check("t3_rr_we_last", 32'(rf_we_rr), 32'h1);
    check("t3_rr_waddr_last", 32'(rf_waddr_rr), 32'd3);
    check("t3_rr_wdata_last", rf_wdata_rr, 32'hC2C2C2C2);

    // Strict priority: requester 2 starves while requester 0 is valid
    step();
    req_valid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      push(5'd1, 32'hA0A0A0A0, 32'h00001000);
      #1;
      check("t4_grant0", 32'(req_ready), 32'h1);
      step();
    end
    req_valid = 3'b100;
    push(5'd3, 32'hC2C2C2C2, 32'h00001008);
    #1;
    check("t4_grant2", 32'(req_ready), 32'h4);
    step();
    req_valid = 3'b000;
    check("t4_waddr2", 32'(rf_waddr), 32'd3);

    // Scoreboard set and clear on r7
    step();
    set_en = 1'b1; set_addr = 5'd7;
    step();
    set_en = 1'b0;
    check("t5_busy_set", busy, 32'h00000080);
    set_req(1, 5'd7, 32'h00000077, 32'h00002000);
    req_valid = 3'b010;
    push(5'd7, 32'h00000077, 32'h00002000);
    #1;
    check("t5_ready1", 32'(req_ready), 32'h2);
    step();
    req_valid = 3'b000;
    check("t5_busy_during", busy, 32'h00000080);
    step();
    check("t5_busy_clr", busy, 32'h0);
    set_en = 1'b1; set_addr = 5'd7;
    step();
    set_en = 1'b0;
    set_req(2, 5'd7, 32'h00000088, 32'h00002004);
    req_valid = 3'b100;
    push(5'd7, 32'h00000088, 32'h00002004);
    step();
    req_valid = 3'b000;
    set_en = 1'b1; set_addr = 5'd7;
    step();
    set_en = 1'b0;
    check("t5_set_wins", busy, 32'h00000080);

    // r0 write, r0 set, flush
    set_req(0, 5'd0, 32'h0000AAAA, 32'h00003000);
    req_valid = 3'b001;
    #1;
    check("t6_r0_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 3'b000;
    check("t6_r0_we", 32'(rf_we), 32'h0);
    set_en = 1'b1; set_addr = 5'd0;
    step();
    check("t6_busy_r0", busy, 32'h00000080);
    for (int r = 4; r < 7; r++) begin
      set_addr = 5'(r);
      step();
    end
    set_en = 1'b0;
    check("t6_busy_f0", busy, 32'h000000F0);
    flush = 1'b1;
    set_en = 1'b1; set_addr = 5'd9;
    set_req(0, 5'd1, 32'h00000005, 32'h00003004);
    req_valid = 3'b001;
    #1;
    check("t6_flush_ready", 32'(req_ready), 32'h0);
    check("t6_flush_ready_rr", 32'(req_ready_rr), 32'h0);
    step();
    flush = 1'b0; set_en = 1'b0;
    check("t6_flush_busy", busy, 32'h0);
    check("t6_flush_we", 32'(rf_we), 32'h0);
    push(5'd1, 32'h00000005, 32'h00003004);
    #1;
    check("t6_post_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 3'b000;
    check("t6_post_waddr", 32'(rf_waddr), 32'd1);

    step(); step();
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
